// File: rtl/ram_dp_init.sv
// ram_dp_init: dual-port synchronous RAM with a built-in clear engine.
// All sequential logic updates on the falling edge of clock.
// Ports:
//   clock, reset_n   negedge clock, asynchronous active-low reset
//   clear            request a full rewrite of INIT_VALUE to every word
//   ready            high while the RAM accepts accesses
//   a_cs/a_we/a_be/a_addr/a_din -> a_dout/a_valid   read/write port, byte enables
//   b_cs/b_addr      -> b_dout/b_valid              read-only port
module ram_dp_init #(
  parameter int unsigned             DATA_WIDTH = 32,
  parameter int unsigned             ADDR_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0]   INIT_VALUE = '0
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      clear,
  output logic                      ready,
  input  logic                      a_cs,
  input  logic                      a_we,
  input  logic [DATA_WIDTH/8-1:0]   a_be,
  input  logic [ADDR_WIDTH-1:0]     a_addr,
  input  logic [DATA_WIDTH-1:0]     a_din,
  output logic [DATA_WIDTH-1:0]     a_dout,
  output logic                      a_valid,
  input  logic                      b_cs,
  input  logic [ADDR_WIDTH-1:0]     b_addr,
  output logic [DATA_WIDTH-1:0]     b_dout,
  output logic                      b_valid
);

  localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
  localparam int unsigned NB       = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  state, state_d;
  logic [ADDR_WIDTH-1:0]   cnt, cnt_d;
  logic                    init_we;
  logic                    run_ok;
  logic                    a_wr, a_rd, b_rd;
  logic [DATA_WIDTH-1:0]   a_old, a_merged;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // State and clear-counter register
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Next-state logic; a clear always wins over any pending write or access
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    init_we = 1'b0;
    run_ok  = 1'b0;
    case (state)
      ST_INIT: begin
        if (clear) begin
          cnt_d = '0;
        end else begin
          init_we = 1'b1;
          cnt_d   = cnt + ADDR_WIDTH'(1);
          if (cnt == LAST_ADDR) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (clear) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end else begin
          run_ok = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign a_wr = run_ok & a_cs & a_we;
  assign a_rd = run_ok & a_cs & ~a_we;
  assign b_rd = run_ok & b_cs;

  // Byte-merged write word; also forwarded to port B on same-address collision
  always_comb begin
    a_old    = mem[a_addr];
    a_merged = a_old;
    for (int i = 0; i < NB; i++) begin
      if (a_be[i]) a_merged[8*i +: 8] = a_din[8*i +: 8];
    end
  end

  // Storage array: deliberately not reset, the clear engine initialises it
  always_ff @(negedge clock) begin
    if (init_we) begin
      mem[cnt] <= INIT_VALUE;
    end else if (a_wr) begin
      mem[a_addr] <= a_merged;
    end
  end

  // Registered outputs
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ready   <= 1'b0;
      a_dout  <= '0;
      b_dout  <= '0;
      a_valid <= 1'b0;
      b_valid <= 1'b0;
    end else begin
      ready   <= (state_d == ST_RUN);
      a_valid <= a_rd;
      b_valid <= b_rd;
      if (a_rd) a_dout <= a_old;
      if (b_rd) b_dout <= (a_wr && (a_addr == b_addr)) ? a_merged : mem[b_addr];
    end
  end

endmodule

// File: tb/tb_ram_dp_init.sv
// Self-checking bench for ram_dp_init: a behavioural model updated on every
// negedge, checked against the DUT on every posedge, plus directed literal checks.
module tb_ram_dp_init;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned DEPTH = 32;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          clear = 1'b0;
  logic          ready;
  logic          a_cs = 1'b0, a_we = 1'b0;
  logic [3:0]    a_be = 4'h0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_din = '0;
  logic [DW-1:0] a_dout;
  logic          a_valid;
  logic          b_cs = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_dout;
  logic          b_valid;

  int tests = 0;
  int fails = 0;

  ram_dp_init dut (
    .clock(clock), .reset_n(reset_n), .clear(clear), .ready(ready),
    .a_cs(a_cs), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout), .a_valid(a_valid),
    .b_cs(b_cs), .b_addr(b_addr), .b_dout(b_dout), .b_valid(b_valid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Behavioural model: memory contents, remaining clear edges, visible outputs
  logic [DW-1:0] m_mem [DEPTH];
  int            m_left;
  logic          m_ready, m_av, m_bv;
  logic [DW-1:0] m_ad, m_bd;

  always @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_left = DEPTH; m_ready = 0; m_ad = '0; m_bd = '0; m_av = 0; m_bv = 0;
    end else if (!m_ready) begin
      m_av = 0; m_bv = 0;
      if (clear) m_left = DEPTH;
      else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
          m_ready = 1;
        end
      end
    end else if (clear) begin
      m_ready = 0; m_left = DEPTH; m_av = 0; m_bv = 0;
    end else begin
      // A write lands first, so a same-address B read sees the new bytes
      if (a_cs && a_we)
        for (int i = 0; i < 4; i++)
          if (a_be[i]) m_mem[a_addr][8*i +: 8] = a_din[8*i +: 8];
      m_av = a_cs && !a_we;
      if (m_av) m_ad = m_mem[a_addr];
      m_bv = b_cs;
      if (m_bv) m_bd = m_mem[b_addr];
    end
  end

  // Compare every cycle, away from the active (falling) edge
  always @(posedge clock) begin
    chk("ready", 32'(ready), 32'(m_ready));
    chk("a_valid", 32'(a_valid), 32'(m_av));
    chk("b_valid", 32'(b_valid), 32'(m_bv));
    chk("a_dout", a_dout, m_ad);
    chk("b_dout", b_dout, m_bd);
  end

  task automatic step();
    @(negedge clock);
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    clear = 0; a_cs = 0; a_we = 0; a_be = 4'h0; b_cs = 0;
  endtask

  task automatic a_write(input logic [AW-1:0] ad, input logic [DW-1:0] d, input logic [3:0] be);
    a_cs = 1; a_we = 1; a_addr = ad; a_din = d; a_be = be;
  endtask

  task automatic a_read(input logic [AW-1:0] ad);
    a_cs = 1; a_we = 0; a_addr = ad; a_be = 4'h0;
  endtask

  task automatic wait_init(input string nm);
    for (int i = 1; i <= int'(DEPTH); i++) begin
      step();
      chk(nm, 32'(ready), 32'(i == int'(DEPTH)));
    end
  endtask

  initial begin
    idle();
    #22;
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_a_dout", a_dout, 32'h0);
    @(posedge clock); #1;
    reset_n = 1;
    wait_init("init_ready");

    // Reads after the initial clear
    a_read(5'd0);  step(); chk("rd0_v", 32'(a_valid), 32'h1); chk("rd0", a_dout, 32'h0);
    a_read(5'd17); step(); chk("rd17", a_dout, 32'h0);
    a_read(5'd31); step(); chk("rd31_v", 32'(a_valid), 32'h1);

    // Byte-enable merge
    a_write(5'd5, 32'hDEADBEEF, 4'b1111); step(); chk("wr_av", 32'(a_valid), 32'h0);
    a_write(5'd5, 32'h0000AA00, 4'b0010); step();
    a_read(5'd5); step(); chk("be_merge", a_dout, 32'hDEADAAEF);

    // Write-through collision on port B
    a_write(5'd9, 32'h12345678, 4'b1111); b_cs = 1; b_addr = 5'd9; step();
    chk("coll_b", b_dout, 32'h12345678); chk("coll_bv", 32'(b_valid), 32'h1);
    b_cs = 0; a_read(5'd9); step(); chk("coll_a", a_dout, 32'h12345678);

    // Partial-byte collision: B sees merged word
    a_write(5'd9, 32'hFFFFFFFF, 4'b0001); b_cs = 1; b_addr = 5'd9; step();
    chk("coll_part", b_dout, 32'h123456FF);
    b_cs = 0;

    // Zero byte enables leave memory untouched
    a_write(5'd3, 32'h11111111, 4'b1111); step();
    a_write(5'd3, 32'h22222222, 4'b0000); step();
    a_read(5'd3); step(); chk("be0", a_dout, 32'h11111111);
    idle(); step();
    chk("idle_av", 32'(a_valid), 32'h0); chk("idle_bv", 32'(b_valid), 32'h0);
    chk("idle_hold", a_dout, 32'h11111111);

    // Dual read of the same address
    a_read(5'd5); b_cs = 1; b_addr = 5'd5; step();
    chk("dual_a", a_dout, 32'hDEADAAEF); chk("dual_b", b_dout, 32'hDEADAAEF);
    idle();

    // Clear in RUN drops the concurrent write
    clear = 1; a_write(5'd2, 32'hFFFFFFFF, 4'b1111); step();
    chk("clr_ready", 32'(ready), 32'h0); chk("clr_av", 32'(a_valid), 32'h0);
    idle();
    wait_init("clr_init");
    a_read(5'd2); step(); chk("clr_rd2", a_dout, 32'h0);
    a_read(5'd5); step(); chk("clr_rd5", a_dout, 32'h0);

    // Load non-zero outputs, then enter INIT and check they hold
    a_write(5'd1, 32'hCAFEF00D, 4'b1111); step();
    a_read(5'd1); b_cs = 1; b_addr = 5'd1; step();
    chk("pre_a", a_dout, 32'hCAFEF00D); chk("pre_b", b_dout, 32'hCAFEF00D);
    idle(); clear = 1; step(); clear = 0;
    a_read(5'd1); b_cs = 1;
    for (int i = 0; i < 10; i++) step();
    chk("init_hold", a_dout, 32'hCAFEF00D);
    chk("init_av", 32'(a_valid), 32'h0);

    // Asynchronous reset mid-INIT
    idle();
    reset_n = 0; #1;
    chk("arst_a", a_dout, 32'h0); chk("arst_b", b_dout, 32'h0);
    chk("arst_ready", 32'(ready), 32'h0);
    @(posedge clock); #1; reset_n = 1;
    for (int i = 0; i < 10; i++) step();
    clear = 1; step(); clear = 0;
    chk("iclr_ready", 32'(ready), 32'h0);
    wait_init("iclr_init");
    a_read(5'd1); step(); chk("final_rd1", a_dout, 32'h0);
    idle(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
